// File: rtl/sample_replay.sv
// Multi-channel sample replay engine: per-channel sample memories replayed in lock-step
// as a strobed stream, configured over the settings bus.
module sample_replay #(
   parameter int unsigned NUM_CHAN           = 2,
   parameter int unsigned SAMPLE_WIDTH       = 32,
   parameter int unsigned ADDR_WIDTH         = 10,
   parameter logic [7:0]  SR_REPLAY_CTRL     = 8'd40,
   parameter logic [7:0]  SR_REPLAY_LEN      = 8'd41,
   parameter logic [7:0]  SR_REPLAY_INTERVAL = 8'd42,
   localparam int unsigned CHAN_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             enable,
   input  logic                             set_stb,
   input  logic [7:0]                       set_addr,
   input  logic [31:0]                      set_data,
   input  logic                             wr_en,
   input  logic [CHAN_W-1:0]                wr_chan,
   input  logic [ADDR_WIDTH-1:0]            wr_addr,
   input  logic [SAMPLE_WIDTH-1:0]          wr_data,
   output logic [NUM_CHAN*SAMPLE_WIDTH-1:0] sample_out,
   output logic                             sample_out_strobe,
   output logic [ADDR_WIDTH-1:0]            sample_idx,
   output logic                             busy,
   output logic                             done,
   output logic [15:0]                      wrap_count
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e                            state_q, state_d;
   logic [15:0]                       cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]             addr_q, addr_d;
   logic [15:0]                       wrap_q, wrap_d;
   logic [ADDR_WIDTH:0]               len_q, len_d;
   logic [15:0]                       interval_q, interval_d;
   logic                              loop_q, loop_d;
   logic [ADDR_WIDTH:0]               len_sh_q;
   logic [15:0]                       interval_sh_q;
   logic [NUM_CHAN*SAMPLE_WIDTH-1:0]  out_hold_q, out_hold_d;
   logic [ADDR_WIDTH-1:0]             idx_hold_q, idx_hold_d;
   logic [NUM_CHAN*SAMPLE_WIDTH-1:0]  rd_flat;

   logic ctrl_wr, start_req, stop_req, strobe, last;
   logic unused_set_data;

   assign unused_set_data = ^set_data[31:16];

   assign ctrl_wr   = set_stb && (set_addr == SR_REPLAY_CTRL);
   assign stop_req  = ctrl_wr && set_data[2];
   assign start_req = ctrl_wr && set_data[0] && !set_data[2];
   assign strobe    = (state_q == StRun) && enable && (cnt_q == 16'd0);
   assign last      = ({1'b0, addr_q} == (len_q - LEN_ONE));

   // Memory reads run every cycle on addr_q, so the sample for the next strobe is always
   // prefetched at least one cycle ahead (interval is never below 2).
   for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
      logic [SAMPLE_WIDTH-1:0] mem [DEPTH];
      logic [SAMPLE_WIDTH-1:0] rd_q;

      always_ff @(posedge clock) begin
         if (wr_en && (wr_chan == CHAN_W'(c))) begin
            mem[wr_addr] <= wr_data;
         end
         rd_q <= mem[addr_q];
      end

      assign rd_flat[c*SAMPLE_WIDTH +: SAMPLE_WIDTH] = rd_q;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wrap_d     = wrap_q;
      len_d      = len_q;
      interval_d = interval_q;
      loop_d     = loop_q;
      out_hold_d = out_hold_q;
      idx_hold_d = idx_hold_q;

      if (strobe) begin
         out_hold_d = rd_flat;
         idx_hold_d = addr_q;
      end

      case (state_q)
         StIdle, StDone: begin
            if (stop_req) begin
               state_d = StIdle;
            end else if (start_req) begin
               len_d      = len_sh_q;
               interval_d = interval_sh_q;
               loop_d     = set_data[1];
               wrap_d     = 16'd0;
               addr_d     = '0;
               cnt_d      = interval_sh_q - 16'd1;
               state_d    = (len_sh_q == '0) ? StDone : StRun;
            end
         end
         StRun: begin
            if (stop_req) begin
               state_d = StIdle;
            end else if (enable) begin
               if (cnt_q == 16'd0) begin
                  cnt_d = interval_q - 16'd1;
                  if (last) begin
                     if (loop_q) begin
                        addr_d = '0;
                        if (wrap_q != 16'hFFFF) begin
                           wrap_d = wrap_q + 16'd1;
                        end
                     end else begin
                        state_d = StDone;
                     end
                  end else begin
                     addr_d = addr_q + ADDR_ONE;
                  end
               end else begin
                  cnt_d = cnt_q - 16'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= StIdle;
         cnt_q         <= 16'd0;
         addr_q        <= '0;
         wrap_q        <= 16'd0;
         len_q         <= '0;
         interval_q    <= 16'd5;
         loop_q        <= 1'b0;
         len_sh_q      <= '0;
         interval_sh_q <= 16'd5;
         out_hold_q    <= '0;
         idx_hold_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wrap_q     <= wrap_d;
         len_q      <= len_d;
         interval_q <= interval_d;
         loop_q     <= loop_d;
         out_hold_q <= out_hold_d;
         idx_hold_q <= idx_hold_d;
         if (set_stb && (set_addr == SR_REPLAY_LEN)) begin
            len_sh_q <= set_data[ADDR_WIDTH:0];
         end
         if (set_stb && (set_addr == SR_REPLAY_INTERVAL)) begin
            interval_sh_q <= (set_data[15:0] < 16'd2) ? 16'd2 : set_data[15:0];
         end
      end
   end

   // Between strobes the outputs show the held copy of the last emitted sample.
   assign sample_out_strobe = strobe;
   assign sample_out        = strobe ? rd_flat : out_hold_q;
   assign sample_idx        = strobe ? addr_q : idx_hold_q;
   assign busy              = (state_q == StRun);
   assign done              = (state_q == StDone);
   assign wrap_count        = wrap_q;

endmodule
